// File: rtl/rv_mem_pkg.sv
// Memory-access definitions shared by the load and store data paths.
package rv_mem_pkg;

    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    typedef struct packed {
        logic [31:0]          addr;
        logic [31:0]          wdata;
        logic [NUM_LANES-1:0] wstrb;
    } st_entry_t;

    // Alignment rule shared by both paths: halves on even bytes, words on word boundaries.
    function automatic logic access_legal(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_SB:   return 1'b1;
            F3_SH:   return ~off[0];
            F3_SW:   return off == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Execute-side store request and memory-side write port of the store buffer.
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          st_valid;
    logic          st_ready;
    logic [2:0]    st_funct3;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic          st_err;
    logic          mem_req;
    logic          mem_gnt;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          empty;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_funct3, st_addr, st_data, mem_gnt,
        input  st_ready, st_err, mem_req, mem_addr, mem_wdata, mem_wstrb, empty, count
    );

    modport slave (
        input  st_valid, st_funct3, st_addr, st_data, mem_gnt,
        output st_ready, st_err, mem_req, mem_addr, mem_wdata, mem_wstrb, empty, count
    );

endinterface

// File: rtl/store_fifo.sv
// Generic in-order FIFO; pointers wrap naturally since DEPTH is a power of two.
module store_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Encodes RV32 SB/SH/SW into word writes with byte strobes and queues them
// in order toward data memory; illegal or misaligned stores raise st_err.
module store_buffer
    import rv_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    store_buffer_if.slave  sb
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = $bits(st_entry_t);

    logic [1:0]                      off;
    logic                            legal;
    logic                            accept;
    logic                            push;
    logic                            pop;
    logic                            full;
    logic                            fifo_empty;
    logic [CW-1:0]                   fifo_count;
    logic                            err_q;
    logic [NUM_LANES-1:0]            enc_strb;
    logic [NUM_LANES-1:0][VEC_W-1:0] enc_data;
    st_entry_t                       enc_entry;
    st_entry_t                       head;
    logic [EW-1:0]                   head_raw;

    assign off    = sb.st_addr[1:0];
    assign legal  = access_legal(sb.st_funct3, off);
    assign accept = sb.st_valid && sb.st_ready;
    assign push   = accept && legal;
    assign pop    = !fifo_empty && sb.mem_gnt;

    always_comb begin
        enc_strb = '0;
        case (sb.st_funct3)
            F3_SB:   enc_strb = 4'b0001 << off;
            F3_SH:   enc_strb = 4'b0011 << off;
            F3_SW:   enc_strb = 4'b1111;
            default: enc_strb = '0;
        endcase
    end

    // Each byte lane picks the source byte that lands there for any legal offset.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        always_comb begin
            case (sb.st_funct3)
                F3_SB:   enc_data[l] = sb.st_data[VEC_W-1:0];
                F3_SH:   enc_data[l] = sb.st_data[(l % 2)*VEC_W +: VEC_W];
                default: enc_data[l] = sb.st_data[l*VEC_W +: VEC_W];
            endcase
        end
    end

    assign enc_entry.addr  = {sb.st_addr[31:2], 2'b00};
    assign enc_entry.wdata = enc_data;
    assign enc_entry.wstrb = enc_strb;

    store_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (enc_entry),
        .dout  (head_raw),
        .count (fifo_count),
        .full  (full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= accept && !legal;
    end

    assign head         = st_entry_t'(head_raw);
    assign sb.st_ready  = !full;
    assign sb.st_err    = err_q;
    assign sb.empty     = fifo_empty;
    assign sb.count     = fifo_count;
    assign sb.mem_req   = !fifo_empty;
    // Head fields are forced to zero when idle so storage never needs a reset.
    assign sb.mem_addr  = fifo_empty ? '0 : head.addr;
    assign sb.mem_wdata = fifo_empty ? '0 : head.wdata;
    assign sb.mem_wstrb = fifo_empty ? '0 : head.wstrb;

endmodule

// File: tb/tb_store_buffer.sv
// Directed and random store traffic checked against a queue-based write model.
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    ent_t mq[$];
    logic err_exp = 1'b0;

    store_buffer_if #(.DEPTH(DEPTH)) sbif();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sbif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic g);
        sbif.st_valid  = v;
        sbif.st_funct3 = f;
        sbif.st_addr   = a;
        sbif.st_data   = d;
        sbif.mem_gnt   = g;
    endtask

    // Check visible state against the model, then apply this cycle's inputs to the model.
    task automatic cycle();
        bit   acc;
        bit   ok;
        int   off;
        ent_t e;
        #3;
        chk("st_ready", {31'b0, sbif.st_ready}, {31'b0, mq.size() != DEPTH});
        chk("count", 32'(sbif.count), 32'(mq.size()));
        chk("empty", {31'b0, sbif.empty}, {31'b0, mq.size() == 0});
        chk("mem_req", {31'b0, sbif.mem_req}, {31'b0, mq.size() != 0});
        chk("st_err", {31'b0, sbif.st_err}, {31'b0, err_exp});
        if (mq.size() != 0) begin
            chk("mem_addr", sbif.mem_addr, mq[0].a);
            chk("mem_wdata", sbif.mem_wdata, mq[0].d);
            chk("mem_wstrb", {28'b0, sbif.mem_wstrb}, {28'b0, mq[0].s});
        end
        acc = sbif.st_valid && (mq.size() != DEPTH);
        off = int'(sbif.st_addr % 4);
        case (sbif.st_funct3)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (off % 2) == 0;
            3'd2:    ok = off == 0;
            default: ok = 1'b0;
        endcase
        if (sbif.mem_gnt && mq.size() != 0) void'(mq.pop_front());
        if (acc && ok) begin
            e.a = sbif.st_addr - 32'(off);
            case (sbif.st_funct3)
                3'd0: begin e.s = 4'(1 << off); e.d = (sbif.st_data % 256) * 32'h0101_0101; end
                3'd1: begin e.s = 4'(3 << off); e.d = (sbif.st_data % 65536) * 32'h0001_0001; end
                default: begin e.s = 4'hF; e.d = sbif.st_data; end
            endcase
            mq.push_back(e);
        end
        err_exp = acc && !ok;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic g);
        for (int i = 0; i < n; i++) begin
            drv(1'b0, 3'd0, 32'h0, 32'h0, g);
            cycle();
        end
    endtask

    initial begin
        drv(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'b0, sbif.st_ready}, 32'd1);
        chk("rst_empty", {31'b0, sbif.empty}, 32'd1);
        chk("rst_count", 32'(sbif.count), 32'd0);
        chk("rst_req", {31'b0, sbif.mem_req}, 32'd0);
        chk("rst_err", {31'b0, sbif.st_err}, 32'd0);
        chk("rst_addr", sbif.mem_addr, 32'd0);
        chk("rst_wdata", sbif.mem_wdata, 32'd0);
        chk("rst_wstrb", {28'b0, sbif.mem_wstrb}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2, 1'b0);

        // SB to the top byte, grant held high
        drv(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 1'b1);
        cycle();
        drv(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        #1;
        chk("sb_addr", sbif.mem_addr, 32'h0000_1000);
        chk("sb_wstrb", {28'b0, sbif.mem_wstrb}, 32'h8);
        chk("sb_wdata", sbif.mem_wdata, 32'hA5A5_A5A5);
        idle(3, 1'b1);

        // SH aligned then misaligned
        drv(1'b1, 3'd1, 32'h0000_2002, 32'h1234_BEEF, 1'b0);
        cycle();
        drv(1'b1, 3'd1, 32'h0000_2001, 32'h1234_BEEF, 1'b0);
        #1;
        chk("sh_wstrb", {28'b0, sbif.mem_wstrb}, 32'hC);
        chk("sh_wdata", sbif.mem_wdata, 32'hBEEF_BEEF);
        cycle();
        drv(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("sh_err_pulse", {31'b0, sbif.st_err}, 32'd1);
        chk("sh_err_count", 32'(sbif.count), 32'd1);
        idle(4, 1'b1);

        // Back-to-back rejects: bad funct3 then misaligned SW
        drv(1'b1, 3'd5, 32'h0000_0000, 32'h1, 1'b0);
        cycle();
        drv(1'b1, 3'd2, 32'h0000_0102, 32'h2, 1'b0);
        cycle();
        idle(2, 1'b0);

        // SW held off by grant for 5 cycles
        drv(1'b1, 3'd2, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0);
        cycle();
        idle(5, 1'b0);
        idle(3, 1'b1);

        // Overfill with grant low, then drain
        for (int i = 0; i <= DEPTH; i++) begin
            drv(1'b1, 3'd2, 32'h0000_4000 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 1'b0);
            cycle();
        end
        drv(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("full_count", 32'(sbif.count), 32'(DEPTH));
        chk("full_ready", {31'b0, sbif.st_ready}, 32'd0);
        idle(DEPTH + 2, 1'b1);

        // Concurrent accept and pop at count 2
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 3'd2, 32'h0000_5000 + 32'(4*i), 32'h5000 + 32'(i), 1'b0);
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, 3'($urandom_range(0, 2)), 32'h0000_6000 + 32'(4*i), $urandom, 1'b1);
            cycle();
        end
        drv(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        #1;
        chk("conc_count", 32'(sbif.count), 32'd2);
        idle(3, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)),
                $urandom, $urandom, 1'($urandom_range(0, 2) != 0));
            cycle();
        end
        idle(DEPTH + 2, 1'b1);

        // Reset with three stores buffered
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 3'd2, 32'h0000_7000 + 32'(4*i), 32'h7000 + 32'(i), 1'b0);
            cycle();
        end
        drv(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        chk("pre_rst_count", 32'(sbif.count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'b0, sbif.mem_req}, 32'd0);
        chk("midrst_count", 32'(sbif.count), 32'd0);
        chk("midrst_empty", {31'b0, sbif.empty}, 32'd1);
        mq.delete();
        err_exp = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store-side counterpart of the load data path: accepts RV32 store operations (SB/SH/SW) from the execute stage, converts each into a word-aligned memory write with byte strobes and lane-replicated data, and queues them in a small in-order buffer that drains to data memory over a request/grant handshake. Misaligned or illegal stores are rejected with an error pulse. It sits between the execute stage and the data memory write port.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥ 2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request from execute stage
- st_ready  out  1  buffer can accept a request this cycle
- st_funct3  in  3  store width: 000 SB, 001 SH, 010 SW
- st_addr  in  32  byte address (rs1 + imm)
- st_data  in  32  rs2 value, data in low bits
- mem_req  out  1  head entry valid toward memory
- mem_gnt  in  1  memory accepts head entry this cycle
- mem_addr  out  32  word address, {st_addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated write data
- mem_wstrb  out  4  byte-lane write enables
- st_err  out  1  one-cycle pulse: rejected store
- empty  out  1  no stores pending (used for load ordering)
- count  out  $clog2(DEPTH+1)  number of stores buffered

## Operation
- Accept on st_valid && st_ready; st_ready = (count != DEPTH).
- Encode at accept, off = st_addr[1:0]:
  - SB: wstrb = 4'b0001 << off; wdata = {4{st_data[7:0]}}.
  - SH: legal only if off[0]==0; wstrb = 4'b0011 << off; wdata = {2{st_data[15:0]}}.
  - SW: legal only if off==0; wstrb = 4'b1111; wdata = st_data.
  - Any other funct3, or misaligned SH/SW: request consumed (handshake completes), nothing enqueued, st_err = 1 the following cycle only.
- Queue is strictly FIFO; the entry holds {word addr, wdata, wstrb}.
- mem_req = !empty; mem_addr/mem_wdata/mem_wstrb show the head entry and stay stable while mem_req && !mem_gnt.
- Pop on mem_req && mem_gnt; mem_gnt while mem_req=0 is ignored.
- Simultaneous accept and pop: count unchanged, both pointers advance; allowed at any fill level except that accept is blocked when full (no pass-through on full).
- Pointers wrap modulo DEPTH; full/empty derived from count.

## Timing
- Reset (async assert, sync release): pointers 0, count 0, empty 1, mem_req 0, st_err 0, st_ready 1; mem_addr/wdata/wstrb 0.
- Latency: a store accepted in cycle N drives mem_req in cycle N+1 at the earliest; no combinational path from st_* to mem_*.
- st_ready depends only on registered count; no path from mem_gnt to st_ready.
- Throughput: one accept and one pop per cycle sustained.
- st_err registered, asserted exactly one cycle per rejected request; back-to-back rejects give back-to-back pulses.
- Reset mid-operation: all buffered stores discarded, mem_req drops immediately (asynchronous).

## Structure
- Shared package rv_mem_pkg: opcode STORE 7'b0100011, funct3 constants F3_SB/F3_SH/F3_SW (also used by the load path for LB/LH/LW), entry struct type {addr, wdata, wstrb}.
- One sub-module: store_fifo (generic synchronous FIFO, DEPTH × entry width, count/full/empty outputs); encoding and error logic stay in store_buffer.

## Test plan
- SB addr 0x1003, data 0x000000A5, gnt held high → one mem cycle: addr 0x1000, wstrb 4'b1000, wdata 0xA5A5A5A5; empty returns to 1.
- SH addr 0x2002, data 0x1234BEEF → wstrb 4'b1100, wdata 0xBEEFBEEF; SH addr 0x2001 → nothing enqueued, st_err pulse 1 cycle, count unchanged.
- SW addr 0x3000 data 0xDEADBEEF with mem_gnt low 5 cycles → mem_req and outputs stable 5 cycles, popped on cycle gnt=1.
- DEPTH+1 back-to-back SW with gnt low → st_ready falls after DEPTH accepts, count = DEPTH; raise gnt → drains in order, one per cycle.
- Concurrent accept and pop at count=2 for 10 cycles → count stays 2, memory sees stores in issue order.
- Assert rst_n low with 3 stores buffered → mem_req 0 immediately; after release count 0, empty 1, no stale writes issued.
